ins_fetch: RTL and testbench
============================

INS_FETCH -- requirements
Module: ins_fetch

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, instruction-queue entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 0, fetch address after reset.
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 en  in  1  global ready; low freezes all state, inputs ignored.
REQ-006 ic_req_o  out  1  one-cycle fetch request to icache.
REQ-007 ic_addr_o  out  RAM_ADR_W  fetch address, valid with ic_req_o.
REQ-008 ic_valid_i  in  1  instruction returned this cycle.
REQ-009 ic_inst_i  in  32  returned instruction word.
REQ-010 bp_pc_o  out  RAM_ADR_W  pc to predictor, equals current fetch pc.
REQ-011 bp_br_i  in  1  predictor taken bit for bp_pc_o (combinational).
REQ-012 bp_en_o / bp_abr_o / bp_tpc_o  out  1/1/RAM_ADR_W  predictor update: valid, actual taken, branch pc.
REQ-013 res_en_i / res_taken_i / res_pc_i  in  1/1/RAM_ADR_W  branch resolution from execute.
REQ-014 flush_i / flush_pc_i  in  1/RAM_ADR_W  redirect on mispredict or jalr.
REQ-015 dec_valid_o / dec_inst_o / dec_pc_o / dec_pbr_o  out  1/32/RAM_ADR_W/1  queue head to decoder; pbr = predicted taken.
REQ-016 dec_ready_i  in  1  decoder accepts head.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, HOLD, DROP.
REQ-018 IDLE: if queue count < QUEUE_DEPTH, assert ic_req_o one cycle with ic_addr_o = pc, go WAIT; else stay.
REQ-019 WAIT on ic_valid_i: push {inst, pc, pbr}; update pc; go HOLD if opcode JALR, else IDLE.
REQ-020 Next pc: JAL -> pc+J-imm, pbr=1; BRANCH and bp_br_i -> pc+B-imm, pbr=1; else pc+4, pbr=0.
REQ-021 B-imm = sext{inst[31],inst[7],inst[30:25],inst[11:8],0}; J-imm = sext{inst[31],inst[19:12],inst[20],inst[30:21],0}; adds wrap modulo 2^RAM_ADR_W.
REQ-022 HOLD: no requests until flush_i.
REQ-023 flush_i highest priority, any state: queue cleared, pc <= flush_pc_i, push suppressed; next state DROP if in WAIT without ic_valid_i that cycle, else IDLE.
REQ-024 DROP: discard next ic_valid_i response, then IDLE; flush in DROP updates pc, stays DROP.
REQ-025 At most one request outstanding.
REQ-026 Pop when dec_valid_o && dec_ready_i; dec_valid_o = queue non-empty; head outputs combinational from queue.
REQ-027 Simultaneous push and pop: count unchanged, order preserved; pop on same cycle as flush discarded.
REQ-028 Pointers wrap modulo QUEUE_DEPTH; push never occurs at count == QUEUE_DEPTH.
REQ-029 bp_en_o/bp_abr_o/bp_tpc_o = res_en_i/res_taken_i/res_pc_i registered, 1-cycle latency, independent of flush.
REQ-030 en low: no state, pointer or pc change; ic_req_o low; bp_en_o low.

Reset
REQ-031 On rst: pc = RESET_PC, state IDLE, queue empty, all outputs 0 (bp_pc_o = RESET_PC); rst overrides en and flush_i.
REQ-032 rst mid-WAIT: state IDLE; the pending response is not required to be dropped (icache is reset simultaneously).

Structure
REQ-033 RAM_ADR_W, INST_W=32, opcodes OPC_BRANCH=1100011, OPC_JAL=1101111, OPC_JALR=1100111 and FSM encodings SHALL live in the shared header.
REQ-034 Queue SHALL be sub-module inst_queue (push, pop, clear, full, empty, head data); fetch FSM and predecode in ins_fetch.

Verification
REQ-035 Reset, RESET_PC=0: first ic_req_o with addr 0x0 on first en cycle; ADDI returns -> queue entry pc 0x0, pbr 0, next req 0x4.
REQ-036 BEQ at 0x10 with imm -8, bp_br_i=1 -> next addr 0x08, pbr 1; bp_br_i=0 -> 0x14, pbr 0.
REQ-037 dec_ready_i=0, depth 4: after 4 pushes ic_req_o stays low; one pop -> exactly one new request.
REQ-038 flush_i (pc 0x100) in WAIT before response -> late response discarded, queue empty, next req 0x100.
REQ-039 JALR fetched -> no requests until flush_i; res_en_i=1, taken=1, pc 0x20 -> bp_en_o=1, bp_abr_o=1, bp_tpc_o=0x20 next cycle.

Source files
------------

// File: rtl/ins_fetch_pkg.sv
// ins_fetch_pkg: shared widths, opcodes, fetch FSM encoding and immediate decoders for the fetch stage
package ins_fetch_pkg;
    localparam int RAM_ADR_W = 16;
    localparam int INST_W    = 32;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_e;

    typedef logic [RAM_ADR_W-1:0] addr_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        addr_t             pc;
        logic              pbr;
    } q_entry_t;

    // B-type offset, sign-extended then truncated so pc adds wrap naturally
    function automatic addr_t imm_b(input logic [INST_W-1:0] i);
        return addr_t'(int'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0})));
    endfunction

    // J-type offset, sign-extended then truncated so pc adds wrap naturally
    function automatic addr_t imm_j(input logic [INST_W-1:0] i);
        return addr_t'(int'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0})));
    endfunction
endpackage

// File: rtl/ins_fetch_queue.sv
// inst_queue: circular instruction queue with push, pop, clear and combinational head
module inst_queue
    import ins_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  logic     pop,
    input  logic     clear,
    input  q_entry_t din,
    output q_entry_t dout,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_en, rd_en;
    q_entry_t      mem_q [DEPTH];

    assign full  = cnt_q == CW'(DEPTH);
    assign empty = cnt_q == '0;
    assign dout  = empty ? '0 : mem_q[rd_q];

    // pointer and occupancy update; clear wins over push and pop
    always_comb begin
        wr_en = push && !full && !clear;
        rd_en = pop && !empty && !clear;
        wr_d  = clear ? '0 : wr_q + AW'(wr_en);
        rd_d  = clear ? '0 : rd_q + AW'(rd_en);
        cnt_d = clear ? '0 : cnt_q + CW'(wr_en) - CW'(rd_en);
    end

    // pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // storage array, written only at the tail
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/ins_fetch.sv
// ins_fetch: fetch FSM with predecode-based next-pc prediction feeding an instruction queue
module ins_fetch
    import ins_fetch_pkg::*;
#(
    parameter int    QUEUE_DEPTH = 4,
    parameter addr_t RESET_PC    = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic                 ic_req_o,
    output logic [RAM_ADR_W-1:0] ic_addr_o,
    input  logic                 ic_valid_i,
    input  logic [INST_W-1:0]    ic_inst_i,
    output logic [RAM_ADR_W-1:0] bp_pc_o,
    input  logic                 bp_br_i,
    output logic                 bp_en_o,
    output logic                 bp_abr_o,
    output logic [RAM_ADR_W-1:0] bp_tpc_o,
    input  logic                 res_en_i,
    input  logic                 res_taken_i,
    input  logic [RAM_ADR_W-1:0] res_pc_i,
    input  logic                 flush_i,
    input  logic [RAM_ADR_W-1:0] flush_pc_i,
    output logic                 dec_valid_o,
    output logic [INST_W-1:0]    dec_inst_o,
    output logic [RAM_ADR_W-1:0] dec_pc_o,
    output logic                 dec_pbr_o,
    input  logic                 dec_ready_i
);
    fetch_state_e state_q, state_d;
    addr_t        pc_q, pc_d, npc;
    logic         bp_en_q, bp_en_d, bp_abr_q, bp_abr_d;
    addr_t        bp_tpc_q, bp_tpc_d;
    logic         push, pop, clear, full, empty;
    logic         is_br, is_jal, pbr;
    logic [6:0]   opc;
    q_entry_t     push_ent, head;

    assign opc = ic_inst_i[6:0];

    inst_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .din   (push_ent),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    // fetch state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // next state; a flush with a response still in flight must swallow that response
    always_comb begin
        state_d = state_q;
        if (en) begin
            if (flush_i) state_d = ((state_q == S_WAIT || state_q == S_DROP) && !ic_valid_i) ? S_DROP : S_IDLE;
            else begin
                case (state_q)
                    S_IDLE:  state_d = full ? S_IDLE : S_WAIT;
                    S_WAIT:  state_d = !ic_valid_i ? S_WAIT : (opc == OPC_JALR ? S_HOLD : S_IDLE);
                    S_HOLD:  state_d = S_HOLD;
                    S_DROP:  state_d = ic_valid_i ? S_IDLE : S_DROP;
                    default: state_d = S_IDLE;
                endcase
            end
        end
    end

    // request and queue control derived from state
    always_comb begin
        ic_req_o  = en && !rst && !flush_i && state_q == S_IDLE && !full;
        ic_addr_o = ic_req_o ? pc_q : '0;
        push      = en && !flush_i && state_q == S_WAIT && ic_valid_i;
        pop       = en && !flush_i && !empty && dec_ready_i;
        clear     = en && flush_i;
    end

    // predecode of the returned word and next pc / predictor-update selection
    always_comb begin
        is_br    = opc == OPC_BRANCH;
        is_jal   = opc == OPC_JAL;
        pbr      = is_jal || (is_br && bp_br_i);
        npc      = pc_q + (is_jal ? imm_j(ic_inst_i) : pbr ? imm_b(ic_inst_i) : addr_t'(4));
        pc_d     = !en ? pc_q : flush_i ? flush_pc_i : push ? npc : pc_q;
        bp_en_d  = en ? res_en_i : bp_en_q;
        bp_abr_d = en ? res_taken_i : bp_abr_q;
        bp_tpc_d = en ? res_pc_i : bp_tpc_q;
        push_ent = '{inst: ic_inst_i, pc: pc_q, pbr: pbr};
    end

    // pc and predictor-update registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            bp_en_q  <= 1'b0;
            bp_abr_q <= 1'b0;
            bp_tpc_q <= '0;
        end else begin
            pc_q     <= pc_d;
            bp_en_q  <= bp_en_d;
            bp_abr_q <= bp_abr_d;
            bp_tpc_q <= bp_tpc_d;
        end
    end

    assign bp_pc_o     = pc_q;
    assign bp_en_o     = en && bp_en_q;
    assign bp_abr_o    = bp_abr_q;
    assign bp_tpc_o    = bp_tpc_q;
    assign dec_valid_o = !empty;
    assign dec_inst_o  = head.inst;
    assign dec_pc_o    = head.pc;
    assign dec_pbr_o   = head.pbr;
endmodule

// File: tb/tb_ins_fetch.sv
// tb_ins_fetch: directed and randomized checks of ins_fetch against a queue-based reference model
module tb_ins_fetch;
    import ins_fetch_pkg::*;

    localparam int D = 4;
    localparam int PC_MASK = (1 << RAM_ADR_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst, en, ic_req_o, ic_valid_i, bp_br_i, bp_en_o, bp_abr_o;
    logic                 res_en_i, res_taken_i, flush_i, dec_valid_o, dec_pbr_o, dec_ready_i;
    logic [RAM_ADR_W-1:0] ic_addr_o, bp_pc_o, bp_tpc_o, res_pc_i, flush_pc_i, dec_pc_o;
    logic [31:0]          ic_inst_i, dec_inst_o;

    typedef struct {
        logic [31:0] inst;
        int          pc;
        logic        pbr;
    } ent_t;

    ent_t        mq[$];
    int          m_pc;
    bit          m_out, m_disc, m_hold;
    bit          mb_en, mb_abr;
    int          mb_pc;
    int          c_cnt, c_kind, c_imm;
    logic [31:0] c_inst;
    int          f_kind = -1, f_imm = 0, f_lat = -1;
    int          n_chk = 0, n_pass = 0;
    int          n;

    ins_fetch #(.QUEUE_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .en(en),
        .ic_req_o(ic_req_o), .ic_addr_o(ic_addr_o), .ic_valid_i(ic_valid_i), .ic_inst_i(ic_inst_i),
        .bp_pc_o(bp_pc_o), .bp_br_i(bp_br_i), .bp_en_o(bp_en_o), .bp_abr_o(bp_abr_o), .bp_tpc_o(bp_tpc_o),
        .res_en_i(res_en_i), .res_taken_i(res_taken_i), .res_pc_i(res_pc_i),
        .flush_i(flush_i), .flush_pc_i(flush_pc_i),
        .dec_valid_o(dec_valid_o), .dec_inst_o(dec_inst_o), .dec_pc_o(dec_pc_o), .dec_pbr_o(dec_pbr_o),
        .dec_ready_i(dec_ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %0h want %0h", tag, got, exp);
    endtask

    // icache model: builds the next returned word (kind 0 alu, 1 branch, 2 jal, 3 jalr) and its latency
    task automatic gen();
        int          x, imm;
        logic [31:0] r;
        logic [12:0] b;
        logic [20:0] j;
        r = $urandom();
        x = int'($urandom_range(0, 19));
        c_kind = f_kind >= 0 ? f_kind : x < 11 ? 0 : x < 16 ? 1 : x < 19 ? 2 : 3;
        imm = f_kind >= 0 ? f_imm : c_kind == 2 ? (int'($urandom_range(0, 2047)) - 1024) * 2
                                                : (int'($urandom_range(0, 127)) - 64) * 2;
        c_imm = imm;
        b = imm[12:0];
        j = imm[20:0];
        case (c_kind)
            0:       c_inst = {r[31:7], 7'h13};
            1:       c_inst = {b[12], b[10:5], (f_kind >= 0 ? 13'h0 : r[24:12]), b[4:1], b[11], OPC_BRANCH};
            2:       c_inst = {j[20], j[10:1], j[11], j[19:12], r[11:7], OPC_JAL};
            default: c_inst = {r[31:7], OPC_JALR};
        endcase
        c_cnt = f_lat >= 0 ? f_lat : int'($urandom_range(0, 2));
    endtask

    // one cycle: deliver any due response, compare outputs with the model, advance the model
    task automatic step();
        bit   req, resp, pop, taken;
        ent_t e;
        ic_valid_i = en && m_out && c_cnt == 0;
        ic_inst_i  = ic_valid_i ? c_inst : 32'h0;
        #1;
        req = en && !flush_i && !m_hold && !m_out && mq.size() < D;
        check("req", ic_req_o, req);
        if (req) check("addr", ic_addr_o, m_pc);
        check("bp_pc", bp_pc_o, m_pc);
        check("dec_valid", dec_valid_o, mq.size() > 0);
        if (mq.size() > 0) begin
            check("dec_inst", dec_inst_o, mq[0].inst);
            check("dec_pc", dec_pc_o, mq[0].pc);
            check("dec_pbr", dec_pbr_o, mq[0].pbr);
        end
        check("bp_en", bp_en_o, en && mb_en);
        if (en && mb_en) begin
            check("bp_abr", bp_abr_o, mb_abr);
            check("bp_tpc", bp_tpc_o, mb_pc);
        end
        if (en) begin
            resp = ic_valid_i;
            pop  = dec_ready_i && mq.size() > 0;
            if (resp) m_out = 0;
            else if (m_out && c_cnt > 0) c_cnt--;
            if (flush_i) begin
                mq.delete();
                m_pc   = int'(flush_pc_i);
                m_hold = 0;
                m_disc = m_out;
            end else begin
                if (pop) void'(mq.pop_front());
                if (resp && m_disc) m_disc = 0;
                else if (resp) begin
                    taken  = c_kind == 2 || (c_kind == 1 && bp_br_i);
                    e.inst = c_inst;
                    e.pc   = m_pc;
                    e.pbr  = taken;
                    m_pc   = (m_pc + (taken ? c_imm : 4)) & PC_MASK;
                    mq.push_back(e);
                    if (c_kind == 3) m_hold = 1;
                end
                if (req) begin
                    m_out = 1;
                    gen();
                end
            end
            mb_en  = res_en_i;
            mb_abr = res_taken_i;
            mb_pc  = int'(res_pc_i);
        end
        @(negedge clk);
    endtask

    initial begin
        rst = 1; en = 0; ic_valid_i = 0; ic_inst_i = '0; bp_br_i = 0; res_en_i = 0; res_taken_i = 0;
        res_pc_i = '0; flush_i = 0; flush_pc_i = '0; dec_ready_i = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_req", ic_req_o, 0);
        check("rst_dec_valid", dec_valid_o, 0);
        check("rst_bp_en", bp_en_o, 0);
        check("rst_bp_pc", bp_pc_o, 0);
        check("rst_dec_pc", dec_pc_o, 0);
        // first fetch from reset pc, alu word falls through to pc+4
        rst = 0; en = 1; f_kind = 0; f_lat = 0;
        #1;
        check("first_req", ic_req_o, 1);
        check("first_addr", ic_addr_o, 0);
        step(); step();
        #1;
        check("alu_entry_pc", dec_pc_o, 0);
        check("alu_entry_pbr", dec_pbr_o, 0);
        check("alu_next_addr", ic_addr_o, 16'h4);
        // beq -8 at 0x10, predicted taken then not taken
        f_kind = 1; f_imm = -8;
        flush_i = 1; flush_pc_i = 16'h10; step(); flush_i = 0;
        bp_br_i = 1; step(); step();
        #1;
        check("beq_taken_addr", ic_addr_o, 16'h8);
        check("beq_taken_pbr", dec_pbr_o, 1);
        check("beq_inst", dec_inst_o, 32'hFE000CE3);
        flush_i = 1; step(); flush_i = 0;
        bp_br_i = 0; step(); step();
        #1;
        check("beq_nt_addr", ic_addr_o, 16'h14);
        check("beq_nt_pbr", dec_pbr_o, 0);
        // full queue blocks requests, a single pop lets exactly one through
        f_kind = 0; flush_i = 1; flush_pc_i = 16'h0; step(); flush_i = 0;
        repeat (12) step();
        #1;
        check("full_no_req", ic_req_o, 0);
        check("full_valid", dec_valid_o, 1);
        dec_ready_i = 1; step(); dec_ready_i = 0;
        n = 0;
        repeat (6) begin #1; n += int'(ic_req_o); step(); end
        check("one_pop_one_req", n, 1);
        // flush while waiting: late response dropped, refetch from flush pc
        dec_ready_i = 1; f_lat = 2;
        flush_i = 1; flush_pc_i = 16'h0; step(); flush_i = 0;
        step();
        flush_i = 1; flush_pc_i = 16'h100; step(); flush_i = 0;
        #1;
        check("drop_no_req", ic_req_o, 0);
        step(); step();
        #1;
        check("drop_empty", dec_valid_o, 0);
        check("drop_req", ic_req_o, 1);
        check("drop_addr", ic_addr_o, 16'h100);
        // jalr stalls fetch until flush; predictor update is one cycle behind resolution
        f_lat = 0; f_kind = 3; step(); step(); f_kind = 0;
        res_en_i = 1; res_taken_i = 1; res_pc_i = 16'h20; step();
        res_en_i = 0; res_taken_i = 0;
        #1;
        check("bp_upd_en", bp_en_o, 1);
        check("bp_upd_abr", bp_abr_o, 1);
        check("bp_upd_tpc", bp_tpc_o, 16'h20);
        n = 0;
        repeat (5) begin #1; n += int'(ic_req_o); step(); end
        check("jalr_hold", n, 0);
        flush_i = 1; flush_pc_i = 16'h40; step(); flush_i = 0;
        #1;
        check("jalr_resume_req", ic_req_o, 1);
        check("jalr_resume_addr", ic_addr_o, 16'h40);
        // randomized traffic
        f_kind = -1; f_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            en          = $urandom_range(0, 9) != 0;
            dec_ready_i = $urandom_range(0, 3) != 0;
            bp_br_i     = 1'($urandom());
            res_en_i    = 1'($urandom());
            res_taken_i = 1'($urandom());
            res_pc_i    = RAM_ADR_W'($urandom());
            flush_i     = $urandom_range(0, m_hold ? 3 : 40) == 0;
            flush_pc_i  = RAM_ADR_W'($urandom()) & 16'hfffc;
            step();
        end
        // reset dominates en and flush
        rst = 1; en = 1; flush_i = 1; flush_pc_i = 16'h55; res_en_i = 1;
        @(negedge clk);
        #1;
        check("rst2_req", ic_req_o, 0);
        check("rst2_dec_valid", dec_valid_o, 0);
        check("rst2_bp_pc", bp_pc_o, 0);
        check("rst2_bp_en", bp_en_o, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
